i2c_txn_arbiter: RTL and testbench



---
 rtl/i2c_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/i2c_txn_arbiter.sv | 168 ++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared widths, timeout default and FSM state encoding for the
//               I2C transaction arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  localparam int I2C_ADDR_W          = 7;
  localparam int I2C_DATA_W          = 8;

  // 20 ms at 100 MHz
  localparam int DEFAULT_TIMEOUT_CYC = 2000000;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd2;
  localparam logic [2:0] ST_ABORT     = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Scans requests starting at
//               ptr_i and wraps modulo NUM_REQ; returns one-hot and index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  // First set request at or after ptr_i, wrapping explicitly so that
  // non-power-of-2 NUM_REQ never selects a nonexistent requester.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    valid_o  = 1'b0;
    gnt_o    = '0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_arbiter
// Description : Shares one I2C master between NUM_REQ requesters. Round-robin
//               grant, one master transaction per grant, per-requester
//               done/nack status and an ack-wait watchdog that aborts the
//               master when no completion arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr_i,
  input  logic [I2C_DATA_W*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [NUM_REQ-1:0]            nack_o,
  output logic                          timeout_o,
  output logic                          m_start_o,
  output logic [I2C_ADDR_W-1:0]         m_addr_o,
  output logic [I2C_DATA_W-1:0]         m_data_o,
  output logic                          m_abort_o,
  input  logic                          m_busy_i,
  input  logic                          m_done_i,
  input  logic                          m_nack_i
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0]   C_LAST_IDX    = IDX_W'(NUM_REQ - 1);
  localparam logic [TIMER_W-1:0] C_TIMEOUT_END = TIMER_W'(TIMEOUT_CYC - 1);

  logic [2:0]            state_q,     state_d;
  logic [IDX_W-1:0]      k_q,         k_d;
  logic [NUM_REQ-1:0]    gnt_sel_q,   gnt_sel_d;
  logic [IDX_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [TIMER_W-1:0]    timer_q,     timer_d;
  logic [I2C_ADDR_W-1:0] addr_q,      addr_d;
  logic [I2C_DATA_W-1:0] data_q,      data_d;
  logic                  nack_flag_q, nack_flag_d;
  logic                  to_flag_q,   to_flag_d;

  logic                  arb_valid;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;

  logic [I2C_ADDR_W-1:0] req_addr_arr [NUM_REQ];
  logic [I2C_DATA_W-1:0] req_data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr_arr[g] = req_addr_i[g*I2C_ADDR_W +: I2C_ADDR_W];
    assign req_data_arr[g] = req_data_i[g*I2C_DATA_W +: I2C_DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .valid_o (arb_valid),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx)
  );

  // Next-state logic for the transaction FSM, watchdog timer and latches.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    gnt_sel_d   = gnt_sel_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    data_d      = data_q;
    nack_flag_d = nack_flag_q;
    to_flag_d   = to_flag_q;
    case (state_q)
      ST_IDLE: begin
        // Timer reads 0 during ISSUE, so it counts cycles since m_start_o.
        timer_d = '0;
        if (arb_valid && !m_busy_i) begin
          k_d       = arb_idx;
          gnt_sel_d = arb_gnt;
          addr_d    = req_addr_arr[arb_idx];
          data_d    = req_data_arr[arb_idx];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d     = TIMER_W'(1);
        nack_flag_d = 1'b0;
        to_flag_d   = 1'b0;
        state_d     = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
        // A completion arriving on the timeout cycle takes precedence.
        if (m_done_i) begin
          nack_flag_d = m_nack_i;
          to_flag_d   = 1'b0;
          state_d     = ST_RESP;
        end else if (timer_q == C_TIMEOUT_END) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        nack_flag_d = 1'b1;
        to_flag_d   = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        rr_ptr_d = (k_q == C_LAST_IDX) ? '0 : k_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      gnt_sel_q   <= '0;
      rr_ptr_q    <= '0;
      timer_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      nack_flag_q <= 1'b0;
      to_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      gnt_sel_q   <= gnt_sel_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      nack_flag_q <= nack_flag_d;
      to_flag_q   <= to_flag_d;
    end
  end

  // Outputs decode directly from registered state, so they clear on reset.
  always_comb begin
    gnt_o     = (state_q != ST_IDLE) ? gnt_sel_q : '0;
    done_o    = (state_q == ST_RESP) ? gnt_sel_q : '0;
    nack_o    = (state_q == ST_RESP && nack_flag_q) ? gnt_sel_q : '0;
    timeout_o = (state_q == ST_RESP) && to_flag_q;
    m_start_o = (state_q == ST_ISSUE);
    m_abort_o = (state_q == ST_ABORT);
    m_addr_o  = addr_q;
    m_data_o  = data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_txn_arbiter
// Description : Directed self-checking bench for i2c_txn_arbiter
//               (NUM_REQ=4, TIMEOUT_CYC=100).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_txn_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_i;
  logic [27:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic [3:0]  nack_o;
  logic        timeout_o;
  logic        m_start_o;
  logic [6:0]  m_addr_o;
  logic [7:0]  m_data_o;
  logic        m_abort_o;
  logic        m_busy_i;
  logic        m_done_i;
  logic        m_nack_i;

  int n_checks = 0;
  int n_pass   = 0;

  i2c_txn_arbiter #(
    .NUM_REQ     (4),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .nack_o     (nack_o),
    .timeout_o  (timeout_o),
    .m_start_o  (m_start_o),
    .m_addr_o   (m_addr_o),
    .m_data_o   (m_data_o),
    .m_abort_o  (m_abort_o),
    .m_busy_i   (m_busy_i),
    .m_done_i   (m_done_i),
    .m_nack_i   (m_nack_i)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  // Reset with all inputs quiet; returns at a negedge with rst released.
  task automatic do_reset();
    rst      = 1'b0;
    req_i    = 4'b0000;
    m_busy_i = 1'b0;
    m_done_i = 1'b0;
    m_nack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Bounded wait, sampling on negedges, for the start pulse.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_start_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One-cycle master completion; returns at the negedge of the RESP cycle.
  task automatic pulse_done(input bit nack);
    m_done_i = 1'b1;
    m_nack_i = nack;
    @(negedge clk);
    m_done_i = 1'b0;
    m_nack_i = 1'b0;
  endtask

  task automatic test_reset();
    req_addr_i = {7'h12, 7'h72, 7'h55, 7'h01};
    req_data_i = 32'h44_33_22_11;
    rst        = 1'b0;
    req_i      = 4'b1111;
    m_busy_i   = 1'b0;
    m_done_i   = 1'b0;
    m_nack_i   = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({gnt_o, done_o, nack_o, timeout_o, m_start_o, m_abort_o} !== 15'h0)
      $display("FAIL reset_ctrl: got %h required 0",
               {gnt_o, done_o, nack_o, timeout_o, m_start_o, m_abort_o});
    else n_pass++;
    n_checks++;
    if ({m_addr_o, m_data_o} !== 15'h0)
      $display("FAIL reset_addr_data: got %h required 0", {m_addr_o, m_data_o});
    else n_pass++;
    req_i = 4'b0000;
    rst   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit done_seen;
    do_reset();
    req_addr_i = {7'h00, 7'h00, 7'h00, 7'h72};
    req_data_i = {8'h00, 8'h00, 8'h00, 8'hAA};
    req_i      = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (m_start_o !== 1'b1) $display("FAIL single_start_latency: got %b required 1", m_start_o);
    else n_pass++;
    n_checks++;
    if (gnt_o !== 4'b0001) $display("FAIL single_gnt: got %b required 0001", gnt_o);
    else n_pass++;
    n_checks++;
    if (m_addr_o !== 7'h72) $display("FAIL single_addr: got %h required 72", m_addr_o);
    else n_pass++;
    n_checks++;
    if (m_data_o !== 8'hAA) $display("FAIL single_data: got %h required aa", m_data_o);
    else n_pass++;
    done_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done_o !== 4'b0000) done_seen = 1'b1;
    end
    n_checks++;
    if (done_seen !== 1'b0) $display("FAIL single_early_done: got %b required 0", done_seen);
    else n_pass++;
    pulse_done(1'b0);
    n_checks++;
    if (done_o !== 4'b0001) $display("FAIL single_done: got %b required 0001", done_o);
    else n_pass++;
    n_checks++;
    if ({nack_o, timeout_o} !== 5'b0) $display("FAIL single_nack: got %b required 00000", {nack_o, timeout_o});
    else n_pass++;
    req_i = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({gnt_o, done_o} !== 8'h00) $display("FAIL single_gnt_drop: got %h required 00", {gnt_o, done_o});
    else n_pass++;
    n_checks++;
    if ({m_addr_o, m_data_o} !== {7'h72, 8'hAA})
      $display("FAIL single_hold_latched: got %h required %h", {m_addr_o, m_data_o}, {7'h72, 8'hAA});
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [6:0] exp_addr [4];
    logic [3:0] exp_gnt;
    bit         ok;
    exp_addr = '{7'h01, 7'h55, 7'h72, 7'h12};
    do_reset();
    req_addr_i = {7'h12, 7'h72, 7'h55, 7'h01};
    req_data_i = 32'h44_33_22_11;
    req_i      = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_gnt = 4'(1 << (t % 4));
      wait_start(ok);
      n_checks++;
      if (!ok) $display("FAIL rr_start_t%0d: got no start required start", t);
      else n_pass++;
      n_checks++;
      if (gnt_o !== exp_gnt) $display("FAIL rr_gnt_t%0d: got %b required %b", t, gnt_o, exp_gnt);
      else n_pass++;
      n_checks++;
      if (m_addr_o !== exp_addr[t % 4])
        $display("FAIL rr_addr_t%0d: got %h required %h", t, m_addr_o, exp_addr[t % 4]);
      else n_pass++;
      repeat (3) @(negedge clk);
      pulse_done(1'b0);
      n_checks++;
      if (done_o !== exp_gnt) $display("FAIL rr_done_t%0d: got %b required %b", t, done_o, exp_gnt);
      else n_pass++;
    end
    req_i = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nack();
    bit ok;
    do_reset();
    req_addr_i = {7'h00, 7'h12, 7'h00, 7'h00};
    req_i      = 4'b0100;
    wait_start(ok);
    n_checks++;
    if (!ok || gnt_o !== 4'b0100 || m_addr_o !== 7'h12)
      $display("FAIL nack_issue: got ok=%b gnt=%b addr=%h required 1/0100/12", ok, gnt_o, m_addr_o);
    else n_pass++;
    // Requester withdraws mid-transaction; completion is still reported.
    @(negedge clk);
    req_i = 4'b0000;
    repeat (4) @(negedge clk);
    pulse_done(1'b1);
    n_checks++;
    if (done_o !== 4'b0100) $display("FAIL nack_done: got %b required 0100", done_o);
    else n_pass++;
    n_checks++;
    if (nack_o !== 4'b0100) $display("FAIL nack_flag: got %b required 0100", nack_o);
    else n_pass++;
    n_checks++;
    if (timeout_o !== 1'b0) $display("FAIL nack_timeout: got %b required 0", timeout_o);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    bit ok;
    int abort_at;
    do_reset();
    req_addr_i = {7'h00, 7'h00, 7'h13, 7'h00};
    req_i      = 4'b0010;
    wait_start(ok);
    n_checks++;
    if (!ok) $display("FAIL wd_start: got no start required start");
    else n_pass++;
    abort_at = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (m_abort_o === 1'b1) begin
        abort_at = i;
        break;
      end
    end
    n_checks++;
    if (abort_at != 100) $display("FAIL wd_abort_delay: got %0d required 100", abort_at);
    else n_pass++;
    n_checks++;
    if (gnt_o !== 4'b0010) $display("FAIL wd_gnt_in_abort: got %b required 0010", gnt_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done_o, nack_o, timeout_o} !== {4'b0010, 4'b0010, 1'b1})
      $display("FAIL wd_resp: got done=%b nack=%b to=%b required 0010/0010/1", done_o, nack_o, timeout_o);
    else n_pass++;
    req_i = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_watchdog_race();
    bit ok;
    bit early_abort;
    do_reset();
    req_addr_i = {7'h00, 7'h00, 7'h13, 7'h00};
    req_i      = 4'b0010;
    wait_start(ok);
    early_abort = 1'b0;
    repeat (99) begin
      @(negedge clk);
      if (m_abort_o === 1'b1) early_abort = 1'b1;
    end
    // Completion on the final allowed cycle.
    pulse_done(1'b0);
    n_checks++;
    if ({ok, early_abort, m_abort_o} !== 3'b100)
      $display("FAIL race_no_abort: got ok/early/abort=%b required 100", {ok, early_abort, m_abort_o});
    else n_pass++;
    n_checks++;
    if ({done_o, nack_o, timeout_o} !== {4'b0010, 4'b0000, 1'b0})
      $display("FAIL race_resp: got done=%b nack=%b to=%b required 0010/0000/0", done_o, nack_o, timeout_o);
    else n_pass++;
    req_i = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_busy_gate();
    bit start_seen;
    do_reset();
    req_addr_i = {7'h00, 7'h00, 7'h00, 7'h2C};
    m_busy_i   = 1'b1;
    req_i      = 4'b0001;
    start_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (m_start_o === 1'b1 || gnt_o !== 4'b0000) start_seen = 1'b1;
    end
    n_checks++;
    if (start_seen !== 1'b0) $display("FAIL busy_blocked: got %b required 0", start_seen);
    else n_pass++;
    m_busy_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_start_o !== 1'b1 || m_addr_o !== 7'h2C)
      $display("FAIL busy_release_start: got start=%b addr=%h required 1/2c", m_start_o, m_addr_o);
    else n_pass++;
    repeat (2) @(negedge clk);
    pulse_done(1'b0);
    req_i = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_txn();
    bit ok;
    do_reset();
    req_addr_i = {7'h00, 7'h00, 7'h21, 7'h20};
    // First transaction moves rr_ptr to 1.
    req_i = 4'b0001;
    wait_start(ok);
    repeat (2) @(negedge clk);
    pulse_done(1'b0);
    wait_start(ok);
    repeat (5) @(negedge clk);
    rst   = 1'b0;
    req_i = 4'b0000;
    @(negedge clk);
    n_checks++;
    if ({gnt_o, m_start_o, m_addr_o} !== 12'h000)
      $display("FAIL rst_mid_clear: got gnt=%b start=%b addr=%h required 0/0/0", gnt_o, m_start_o, m_addr_o);
    else n_pass++;
    rst   = 1'b1;
    req_i = 4'b0011;
    @(negedge clk);
    n_checks++;
    if (gnt_o !== 4'b0001 || m_start_o !== 1'b1)
      $display("FAIL rst_mid_rrptr: got gnt=%b start=%b required 0001/1", gnt_o, m_start_o);
    else n_pass++;
    pulse_done(1'b0);
    req_i = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_nack();
    test_watchdog();
    test_watchdog_race();
    test_busy_gate();
    test_reset_mid_txn();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
